tty_iot_responder: RTL

TTY_IOT_RESPONDER -- requirements
Module: tty_iot_responder

---
 rtl/tty_iot_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tty_iot_responder.sv
// Console TTY IOT responder: keyboard (dev 03) and 8N2 serial printer (dev 04) with shared IRQ.
// AC_OUT/AC_CLR/SKIP are same-cycle combinational; KBD_READY drops while KFLAG is set; print loads ignored while busy.
module tty_iot_responder #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IOT603x,
   input  logic       IOT604x,
   input  logic       IOT_STB,
   input  logic [2:0] IR,
   input  logic [7:0] AC_IN,
   input  logic       AC_IN_IE,
   output logic [7:0] AC_OUT,
   output logic       AC_CLR,
   output logic       SKIP,
   output logic       IRQ,
   output logic       TXD,
   input  logic [7:0] KBD_DATA,
   input  logic       KBD_VALID,
   output logic       KBD_READY
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} prt_state_t;

   prt_state_t    state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_nxt;
   logic [7:0]    kbuf;
   logic [7:0]    pbuf;
   logic          kflag;
   logic          pflag;
   logic          ie;
   logic          txd_q;
   logic          irq_q;

   logic kbd_op, prt_op;
   logic kbd_clr, kbd_ie_ld, kbd_accept;
   logic prt_set, prt_clr, prt_load;
   logic bit_end, frame_done;

   assign kbd_op     = IOT_STB & IOT603x;
   assign prt_op     = IOT_STB & IOT604x;
   assign kbd_clr    = kbd_op & ((IR == 3'd0) | (IR == 3'd2) | (IR == 3'd6));
   assign kbd_ie_ld  = kbd_op & (IR == 3'd5);
   assign kbd_accept = KBD_VALID & ~kflag;
   assign prt_set    = prt_op & (IR == 3'd0);
   assign prt_clr    = prt_op & ((IR == 3'd2) | (IR == 3'd6));
   assign prt_load   = prt_op & ((IR == 3'd4) | (IR == 3'd6));

   assign bit_end    = (clk_cnt == CLK_LAST);
   assign bit_nxt    = bit_cnt + 3'd1;
   assign frame_done = (state == STOP) & bit_end & (bit_cnt == 3'd1);

   assign KBD_READY = ~kflag;
   assign TXD       = txd_q;
   assign IRQ       = irq_q;

   // Both devices may be selected at once; their responses are simply ORed.
   always_comb begin
      AC_OUT = 8'h00;
      AC_CLR = 1'b0;
      SKIP   = 1'b0;
      if (kbd_op) begin
         case (IR)
            3'd1: SKIP = kflag;
            3'd2: AC_CLR = 1'b1;
            3'd4: AC_OUT = kbuf;
            3'd6: begin
               AC_CLR = 1'b1;
               AC_OUT = kbuf;
            end
            default: ;
         endcase
      end
      if (prt_op && IR == 3'd1)
         SKIP = SKIP | pflag;
   end

   // An accept can only happen with KFLAG clear, so a coincident clear op has nothing to undo.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         kflag <= 1'b0;
         kbuf  <= 8'h00;
         ie    <= 1'b1;
         pflag <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (kbd_accept) begin
            kflag <= 1'b1;
            kbuf  <= KBD_DATA;
         end else if (kbd_clr) begin
            kflag <= 1'b0;
         end
         if (kbd_ie_ld)
            ie <= AC_IN_IE;
         if (frame_done || prt_set)
            pflag <= 1'b1;
         else if (prt_clr)
            pflag <= 1'b0;
         irq_q <= ie & (kflag | pflag);
      end
   end

   // TXD is registered and updated on the same edge as the state change, so each bit lasts exactly CLKS_PER_BIT cycles.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= 3'd0;
         pbuf    <= 8'h00;
         txd_q   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= 3'd0;
               txd_q   <= 1'b1;
               if (prt_load) begin
                  pbuf  <= AC_IN;
                  state <= START;
                  txd_q <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  state   <= DATA;
                  txd_q   <= pbuf[0];
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     state   <= STOP;
                     bit_cnt <= 3'd0;
                     txd_q   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_nxt;
                     txd_q   <= pbuf[bit_nxt];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 3'd1) begin
                     state   <= IDLE;
                     bit_cnt <= 3'd0;
                  end else begin
                     bit_cnt <= bit_nxt;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
